// File: rtl/rf_pkg.sv
// Shared sizes and types for the RV32I integer register file and its
// in-flight write scoreboard.
package rf_pkg;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 2;
  localparam int NREGS  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [WIDTH-1:0]  word_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam reg_idx_t A0_IDX  = reg_idx_t'(10);
  localparam cnt_t     CNT_MAX = '1;

endpackage

// File: rtl/reg_file_wb_if.sv
// Bundle of writeback, decode-read and scoreboard signals between the
// pipeline (master) and the register file (slave).
interface reg_file_wb_if;
  import rf_pkg::*;

  logic     RegWriteW;
  reg_idx_t RdW;
  word_t    ResultW;
  reg_idx_t A1;
  reg_idx_t A2;
  word_t    RD1;
  word_t    RD2;
  logic     IssueD;
  reg_idx_t RdD;
  logic     CancelE;
  reg_idx_t RdE;
  logic     StallD;
  word_t    a0;

  modport master (
    output RegWriteW, RdW, ResultW, A1, A2, IssueD, RdD, CancelE, RdE,
    input  RD1, RD2, StallD, a0
  );

  modport slave (
    input  RegWriteW, RdW, ResultW, A1, A2, IssueD, RdD, CancelE, RdE,
    output RD1, RD2, StallD, a0
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register in-flight write counters (saturating) and decode stall.
// REGFILE_BYPASS_EN lets a final writeback release the stall in its own cycle.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     issue_en,
  input  reg_idx_t issue_rd,
  input  logic     wb_en,
  input  reg_idx_t wb_rd,
  input  logic     cancel_en,
  input  reg_idx_t cancel_rd,
  input  reg_idx_t src1,
  input  reg_idx_t src2,
  output logic     stall
);

  cnt_t             cnt_q [NREGS];
  cnt_t             cnt_d [NREGS];
  logic [NREGS-1:0] underflow;
  logic             busy1;
  logic             busy2;

  // One extra bit of headroom plus a sign bit: the sum spans -2..+4.
  always_comb begin
    logic [CNT_W+1:0] sum;
    sum       = '0;
    underflow = '0;
    cnt_d[0]  = '0;
    for (int r = 1; r < NREGS; r++) begin
      sum = {2'b00, cnt_q[r]}
          + {{(CNT_W+1){1'b0}}, (issue_en  && (issue_rd  == reg_idx_t'(r)))}
          - {{(CNT_W+1){1'b0}}, (wb_en     && (wb_rd     == reg_idx_t'(r)))}
          - {{(CNT_W+1){1'b0}}, (cancel_en && (cancel_rd == reg_idx_t'(r)))};
      underflow[r] = sum[CNT_W+1];
      if (sum[CNT_W+1]) begin
        cnt_d[r] = '0;
      end else if (sum[CNT_W]) begin
        cnt_d[r] = CNT_MAX;
      end else begin
        cnt_d[r] = sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    busy1 = (src1 != '0) && (cnt_q[src1] != '0);
    busy2 = (src2 != '0) && (cnt_q[src2] != '0);
`ifdef REGFILE_BYPASS_EN
    if (wb_en && (wb_rd == src1) && (cnt_q[src1] == cnt_t'(1))) busy1 = 1'b0;
    if (wb_en && (wb_rd == src2) && (cnt_q[src2] == cnt_t'(1))) busy2 = 1'b0;
`endif
    stall = busy1 | busy2;
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) underflow == '0);
  a_no_issue_on_stall: assert property (@(posedge clk) disable iff (!rst_n) !(issue_en && stall));

endmodule

// File: rtl/reg_file_wb.sv
// RV32I integer register file: writeback port, two async read ports, a0 tap.
// REGFILE_BYPASS_EN makes reads write-through against the current writeback.
module reg_file_wb
  import rf_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  reg_file_wb_if.slave bus
);

  word_t regs_q [NREGS];
  word_t regs_d [NREGS];
  logic  wr_en;
  logic  byp1;
  logic  byp2;

  assign wr_en = bus.RegWriteW && (bus.RdW != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[bus.RdW] = bus.ResultW;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign byp1 = wr_en && (bus.RdW == bus.A1);
  assign byp2 = wr_en && (bus.RdW == bus.A2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign bus.RD1 = (bus.A1 == '0) ? '0 : (byp1 ? bus.ResultW : regs_q[bus.A1]);
  assign bus.RD2 = (bus.A2 == '0) ? '0 : (byp2 ? bus.ResultW : regs_q[bus.A2]);
  assign bus.a0  = regs_q[A0_IDX];

  rf_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue_en  (bus.IssueD),
    .issue_rd  (bus.RdD),
    .wb_en     (bus.RegWriteW),
    .wb_rd     (bus.RdW),
    .cancel_en (bus.CancelE),
    .cancel_rd (bus.RdE),
    .src1      (bus.A1),
    .src2      (bus.A2),
    .stall     (bus.StallD)
  );

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: directed scenarios then random traffic,
// checked against an array/counter model (honours REGFILE_BYPASS_EN).
module tb_reg_file_wb;
  import rf_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_file_wb_if bus ();

  reg_file_wb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int    id;
    word_t rd1;
    word_t rd2;
    word_t a0;
    logic  stall;
  } exp_t;

  exp_t  exp_q [$];
  int    total = 0;
  int    bad = 0;
  int    cycle_id = 0;
  word_t m_regs [NREGS];
  int    m_cnt  [NREGS];

  function automatic logic m_busy(reg_idx_t a, logic wb, reg_idx_t rdw);
    if (a == 0 || m_cnt[a] == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (m_cnt[a] == 1 && wb && rdw == a) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic word_t m_read(reg_idx_t a, logic wb, reg_idx_t rdw, word_t res);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wb && rdw == a) return res;
`endif
    return m_regs[a];
  endfunction

  function automatic reg_idx_t pick_busy();
    int start;
    start = $urandom_range(1, NREGS - 1);
    for (int k = 0; k < NREGS - 1; k++) begin
      int r;
      r = 1 + ((start - 1 + k) % (NREGS - 1));
      if (m_cnt[r] > 0) return reg_idx_t'(r);
    end
    return '0;
  endfunction

  // Drive one cycle: push the expected outputs, then advance the model at the edge.
  task automatic drive(input logic rst, input logic wb, input reg_idx_t rdw, input word_t res,
                       input reg_idx_t a1, input reg_idx_t a2, input logic iss, input reg_idx_t rdd,
                       input logic can, input reg_idx_t rde);
    exp_t e;
    rst_n         = ~rst;
    bus.RegWriteW = wb;
    bus.RdW       = rdw;
    bus.ResultW   = res;
    bus.A1        = a1;
    bus.A2        = a2;
    bus.IssueD    = iss;
    bus.RdD       = rdd;
    bus.CancelE   = can;
    bus.RdE       = rde;
    e.id    = cycle_id;
    e.rd1   = m_read(a1, wb, rdw, res);
    e.rd2   = m_read(a2, wb, rdw, res);
    e.a0    = m_regs[10];
    e.stall = m_busy(a1, wb, rdw) | m_busy(a2, wb, rdw);
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] = '0;
        m_cnt[r]  = 0;
      end
    end else begin
      if (wb && rdw != 0) m_regs[rdw] = res;
      for (int r = 1; r < NREGS; r++) begin
        int n;
        n = m_cnt[r];
        if (iss && rdd == r) n++;
        if (wb && rdw == r) n--;
        if (can && rde == r) n--;
        m_cnt[r] = (n < 0) ? 0 : ((n > 3) ? 3 : n);
      end
    end
    cycle_id++;
    #1;
  endtask

  task automatic idle(input reg_idx_t a1, input reg_idx_t a2);
    drive(1'b0, 1'b0, '0, '0, a1, a2, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic check(input string name, input int id, input word_t got, input word_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s txn=%0d got=%h want=%h", name, id, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("RD1", e.id, bus.RD1, e.rd1);
      check("RD2", e.id, bus.RD2, e.rd2);
      check("a0", e.id, bus.a0, e.a0);
      check("StallD", e.id, word_t'(bus.StallD), word_t'(e.stall));
      $display("txn %0d A1=%0d A2=%0d RD1=%h RD2=%h StallD=%b a0=%h",
               e.id, bus.A1, bus.A2, bus.RD1, bus.RD2, bus.StallD, bus.a0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog txn=%0d got=timeout want=finish", cycle_id);
    $fatal(1);
  end

  initial begin
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_cnt[r]  = 0;
    end
    rst_n = 1'b0;
    bus.RegWriteW = 1'b0; bus.RdW = '0; bus.ResultW = '0;
    bus.A1 = '0; bus.A2 = '0;
    bus.IssueD = 1'b0; bus.RdD = '0; bus.CancelE = 1'b0; bus.RdE = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state across every index
    for (int a = 0; a < NREGS; a++) idle(reg_idx_t'(a), reg_idx_t'(NREGS - 1 - a));

    // Write/readback of x5, ignored write to x0
    drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 5'd5, 1'b0, '0);
    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, '0, '0, 1'b0, '0, 1'b0, '0);
    idle(5'd5, '0);
    drive(1'b0, 1'b1, 5'd0, 32'h0000_1234, 5'd5, 5'd0, 1'b0, '0, 1'b0, '0);
    idle(5'd0, 5'd0);

    // Same-cycle write and read of x7
    drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 5'd7, 1'b0, '0);
    drive(1'b0, 1'b1, 5'd7, 32'h55, 5'd7, '0, 1'b0, '0, 1'b0, '0);
    idle(5'd7, '0);

    // Single in-flight write to x3
    drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 5'd3, 1'b0, '0);
    repeat (3) idle(5'd3, '0);
    drive(1'b0, 1'b1, 5'd3, 32'h3333, 5'd3, '0, 1'b0, '0, 1'b0, '0);
    idle(5'd3, '0);

    // Two issues to x4, one cancelled, one written back
    drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 5'd4, 1'b0, '0);
    drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 5'd4, 1'b0, '0);
    idle('0, 5'd4);
    drive(1'b0, 1'b0, '0, '0, '0, 5'd4, 1'b0, '0, 1'b1, 5'd4);
    idle('0, 5'd4);
    drive(1'b0, 1'b1, 5'd4, 32'h4444, '0, 5'd4, 1'b0, '0, 1'b0, '0);
    idle('0, 5'd4);

    // Reset discards in-flight x9 and clears the file
    drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 5'd9, 1'b0, '0);
    idle(5'd9, 5'd5);
    drive(1'b1, 1'b0, '0, '0, 5'd9, 5'd5, 1'b0, '0, 1'b0, '0);
    idle(5'd9, 5'd5);

    // Random traffic under the decode/writeback protocol
    for (int i = 0; i < 3000; i++) begin
      logic     rst, wb, iss, can;
      reg_idx_t rdw, a1, a2, rdd, rde, r;
      word_t    res;
      rst = ($urandom_range(0, 199) == 0);
      a1  = reg_idx_t'($urandom);
      a2  = reg_idx_t'($urandom);
      res = $urandom;
      rdw = reg_idx_t'($urandom);
      rde = reg_idx_t'($urandom);
      rdd = ($urandom_range(0, 3) == 0) ? 5'd10 : reg_idx_t'($urandom);
      wb  = 1'b0;
      can = 1'b0;
      iss = 1'b0;
      if (!rst) begin
        if ($urandom_range(0, 1) == 1) begin
          r = pick_busy();
          if (r != 0) begin
            wb = 1'b1;
            rdw = r;
          end else if ($urandom_range(0, 3) == 0) begin
            wb = 1'b1;
            rdw = '0;
          end
        end
        if ($urandom_range(0, 2) == 0) begin
          r = pick_busy();
          if (r != 0 && !(wb && rdw == r && m_cnt[r] < 2)) begin
            can = 1'b1;
            rde = r;
          end
        end
        if (!(m_busy(a1, wb, rdw) | m_busy(a2, wb, rdw)) && $urandom_range(0, 1) == 1) iss = 1'b1;
      end
      drive(rst, wb, rdw, res, a1, a2, iss, rdd, can, rde);
    end

    idle('0, '0);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain txn=%0d got=%0d want=0 pending", cycle_id, exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
